// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory with an
// in-order response FIFO, credit-based flow control and flush.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] NOP         = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_addr,
  output logic        resp_err,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0]   LIMIT = 33'(DEPTH_WORDS) << 2;
  localparam logic [PW-1:0] PLAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CMAX  = CW'(FIFO_DEPTH);

  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          r_pv [LATENCY];
  logic [31:0]   r_pa [LATENCY];
  logic [31:0]   r_pd [LATENCY];
  logic          r_pe [LATENCY];

  logic [31:0]   r_fa [FIFO_DEPTH];
  logic [31:0]   r_fd [FIFO_DEPTH];
  logic          r_fe [FIFO_DEPTH];

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_out;

  logic          w_acc;
  logic          w_pop;
  logic          w_push;
  logic          w_empty;
  logic          w_rerr;
  logic          w_wok;
  logic [AW-1:0] w_ridx;
  logic [AW-1:0] w_widx;

  assign w_empty = (r_cnt == '0);
  assign w_acc   = req_valid & req_ready;
  assign w_pop   = ~w_empty & resp_ready & ~flush;
  assign w_push  = r_pv[LATENCY-1] & ~flush;
  assign w_rerr  = (req_addr[1:0] != 2'b00) |
                   ({1'b0, req_addr} >= LIMIT);
  assign w_wok   = ({1'b0, wr_addr} < LIMIT);
  assign w_ridx  = req_addr[AW+1:2];
  assign w_widx  = wr_addr[AW+1:2];

  // Credits come from registered state only.
  assign req_ready  = (r_out < CMAX);
  assign resp_valid = ~w_empty;
  assign resp_instr = w_empty ? NOP   : r_fd[r_rp];
  assign resp_addr  = w_empty ? '0    : r_fa[r_rp];
  assign resp_err   = w_empty ? 1'b0  : r_fe[r_rp];

  // Program-load port; memory survives reset.
  always_ff @(posedge clk) begin
    if (reset && wr_en && w_wok)
      r_mem[w_widx] <= wr_data;
  end

  // Read pipeline: stage 0 samples memory at accept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LATENCY; k++)
        r_pv[k] <= 1'b0;
    end else begin
      r_pv[0] <= w_acc;
      r_pa[0] <= req_addr;
      r_pe[0] <= w_rerr;
      r_pd[0] <= w_rerr ? NOP : r_mem[w_ridx];
      for (int k = 1; k < LATENCY; k++) begin
        r_pv[k] <= r_pv[k-1] & ~flush;
        r_pa[k] <= r_pa[k-1];
        r_pd[k] <= r_pd[k-1];
        r_pe[k] <= r_pe[k-1];
      end
    end
  end

  // Response FIFO storage.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_fa[r_wp] <= r_pa[LATENCY-1];
      r_fd[r_wp] <= r_pd[LATENCY-1];
      r_fe[r_wp] <= r_pe[LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; flush empties.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= (r_wp == PLAST) ? '0 : r_wp + PW'(1);
      if (w_pop)
        r_rp <= (r_rp == PLAST) ? '0 : r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Outstanding = pipeline entries + FIFO entries.
  always_ff @(posedge clk) begin
    if (!reset)
      r_out <= '0;
    else if (flush)
      r_out <= CW'(w_acc);
    else
      r_out <= r_out + CW'(w_acc) - CW'(w_pop);
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: instruction memory size in 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 2: fixed request-to-response latency in cycles, legal range 1..4.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: response buffer depth, which is also the maximum number of outstanding requests.
REQ-004 SHALL have parameter NOP, default 32'h00000013: instruction returned on error.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1: the fetch side presents a request.
REQ-008 SHALL have port req_ready, output, 1: the responder can accept a request.
REQ-009 SHALL have port req_addr, input, 32: byte address of the instruction.
REQ-010 SHALL have port resp_valid, output, 1: the response at the FIFO head is valid.
REQ-011 SHALL have port resp_ready, input, 1: the fetch side consumes the response.
REQ-012 SHALL have port resp_instr, output, 32: instruction word.
REQ-013 SHALL have port resp_addr, output, 32: byte address of the request being answered.
REQ-014 SHALL have port resp_err, output, 1: misaligned or out-of-range request.
REQ-015 SHALL have port flush, input, 1: PC redirect; discard all in-flight work.
REQ-016 SHALL have port wr_en, input, 1: program-load write strobe.
REQ-017 SHALL have port wr_addr, input, 32: byte address of the write; bits [1:0] are ignored.
REQ-018 SHALL have port wr_data, input, 32: word to write.

Function
REQ-019 SHALL accept a request on each rising edge where req_valid and req_ready are both 1.
REQ-020 SHALL index memory with word index = req_addr[log2(DEPTH_WORDS)+1:2], reading the array at the acceptance edge.
REQ-021 SHALL flag an error when req_addr[1:0] != 0 or req_addr >= DEPTH_WORDS*4, returning resp_err=1 and resp_instr=NOP.
REQ-022 SHALL carry each accepted request through a LATENCY-stage valid/addr/data pipeline; an accept at edge N SHALL be pushed into the FIFO at edge N+LATENCY, so resp_valid can be 1 no earlier than after edge N+LATENCY.
REQ-023 SHALL return responses strictly in acceptance order.
REQ-024 SHALL maintain outstanding = (valid pipeline entries) + (FIFO occupancy) as a register.
REQ-025 SHALL drive req_ready = (outstanding < FIFO_DEPTH), decoded from registered state only, with no same-cycle pass-through from resp_ready.
REQ-026 SHALL, by the credit rule in REQ-025, never overflow the FIFO.
REQ-027 SHALL update outstanding so that, in a cycle with both an accept and a pop, the count is unchanged.
REQ-028 SHALL drive resp_valid = FIFO not empty, with resp_instr, resp_addr and resp_err taken from the FIFO head.
REQ-029 SHALL hold all response outputs stable while resp_valid=1 and resp_ready=0.
REQ-030 SHALL pop the FIFO head on each edge where resp_valid and resp_ready are both 1; resp_ready while empty SHALL have no effect.
REQ-031 SHALL, on a flush edge, invalidate all pipeline stages and empty the FIFO.
REQ-032 SHALL retain a request accepted in the same cycle as flush, which then becomes the only outstanding request.
REQ-033 SHALL ignore any pop in a flush cycle.
REQ-034 SHALL write mem[wr_addr word index] <= wr_data on each edge where wr_en=1; out-of-range writes SHALL be dropped.
REQ-035 SHALL, when a write and an accepted read target the same word in the same cycle, return the old data to the read.

Reset
REQ-036 SHALL, on an edge where reset=0, clear all pipeline valids, the FIFO pointers and outstanding; this takes priority over accept, pop, flush and write.
REQ-037 SHALL, after reset, drive resp_valid=0, req_ready=1, resp_instr=NOP, resp_addr=0 and resp_err=0.
REQ-038 SHALL NOT clear memory contents on reset.

Verification
REQ-039 Write word 3 = 0x00500093, then accept a request for 0x0000000C with resp_ready=1 -> resp_valid=1 exactly 2 cycles after accept, resp_instr=0x00500093, resp_addr=0x0C, resp_err=0.
REQ-040 Six back-to-back requests with resp_ready=0 -> exactly 4 accepted and req_ready=0; then raise resp_ready -> 4 in-order responses, with req_ready=1 the cycle after the first pop.
REQ-041 Request 0x00000006 -> resp_err=1, resp_instr=0x00000013; request 0x00001000 (DEPTH_WORDS=1024) -> resp_err=1.
REQ-042 Three requests outstanding, then flush and a request for 0x40 in the same cycle -> only the 0x40 response ever appears; outstanding=1.
REQ-043 reset=0 for one edge mid-stream -> next cycle resp_valid=0, req_ready=1; a re-read of word 3 still returns 0x00500093.
REQ-044 Write 0xDEADBEEF to word 5 while a request for 0x14 is accepted in the same cycle -> that response returns the old word; the next request for 0x14 returns 0xDEADBEEF.
